// File: rtl/dram_multiport_responder_pkg.sv
// Shared definitions for the multiport DRAM responder: access codes and
// host-port FSM states.
package dram_multiport_responder_pkg;

  localparam logic [1:0] CODE_IDLE = 2'b00;
  localparam logic [1:0] CODE_ACC  = 2'b01;

  typedef enum logic [1:0] {
    HOST_IDLE   = 2'd0,
    HOST_LOCKED = 2'd1,
    HOST_RESP   = 2'd2
  } host_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/dram_multiport_responder_if.sv
// One core's DRAM bus: byte address, read/write codes, write data and
// registered read data.
interface dram_multiport_responder_if;
  logic [15:0] addr;
  logic [1:0]  rd_code;
  logic [1:0]  wr_code;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (output addr, rd_code, wr_code, wdata, input rdata);
  modport slave  (input addr, rd_code, wr_code, wdata, output rdata);
endinterface

// File: rtl/dram_port_slice.sv
// Per-port decode: code/range checking, write qualification and the
// registered read-data holder for one core port.
module dram_port_slice
  import dram_multiport_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  dram_multiport_responder_if.slave bus,
  input  logic [7:0]            i_mem_rdata,
  output logic [ADDR_W-1:0]     o_idx,
  output logic                  o_wr_en,
  output logic                  o_err
);

  localparam logic [15:0] HI_MASK = 16'hFFFF << ADDR_W;

  logic       rd_acc;
  logic       wr_acc;
  logic       reserved;
  logic       range_bad;
  logic       rd_en;
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  always_comb begin
    rd_acc    = (bus.rd_code == CODE_ACC);
    wr_acc    = (bus.wr_code == CODE_ACC);
    reserved  = ((bus.rd_code != CODE_IDLE) && !rd_acc) ||
                ((bus.wr_code != CODE_IDLE) && !wr_acc);
    range_bad = (rd_acc || wr_acc) && (|(bus.addr & HI_MASK));
    o_idx     = bus.addr[ADDR_W-1:0];
    o_wr_en   = wr_acc && !range_bad;
    // a simultaneous write takes the port; the read is dropped
    rd_en     = rd_acc && !wr_acc && !range_bad;
    o_err     = reserved || range_bad || (rd_acc && wr_acc);
    rdata_d   = rd_en ? i_mem_rdata : rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: rtl/dram_multiport_responder.sv
// Shared byte memory serving NUM_PORTS core DRAM ports at fixed one-cycle
// latency, plus a host preload/dump port locked out while any core is busy.
module dram_multiport_responder
  import dram_multiport_responder_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [NUM_PORTS*16-1:0] i_dram_addr,
  input  logic [NUM_PORTS*2-1:0]  i_dram_read,
  input  logic [NUM_PORTS*2-1:0]  i_dram_write,
  input  logic [NUM_PORTS*8-1:0]  i_dram_wdata,
  output logic [NUM_PORTS*8-1:0]  o_dram_rdata,
  input  logic [NUM_PORTS-1:0]    i_core_busy,
  input  logic                   i_host_valid,
  input  logic                   i_host_we,
  input  logic [ADDR_W-1:0]      i_host_addr,
  input  logic [7:0]             i_host_wdata,
  output logic                   o_host_ready,
  output logic                   o_host_rvalid,
  output logic [7:0]             o_host_rdata,
  output logic                   o_err,
  output logic [7:0]             o_conflict_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] idx   [NUM_PORTS];
  logic [7:0]        wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_en;
  logic [NUM_PORTS-1:0] port_err;

  dram_multiport_responder_if port_bus [NUM_PORTS] ();

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_bus[g].addr    = i_dram_addr[16*g +: 16];
    assign port_bus[g].rd_code = i_dram_read[2*g +: 2];
    assign port_bus[g].wr_code = i_dram_write[2*g +: 2];
    assign port_bus[g].wdata   = i_dram_wdata[8*g +: 8];
    assign wdata[g]            = port_bus[g].wdata;
    assign o_dram_rdata[8*g +: 8] = port_bus[g].rdata;

    dram_port_slice #(.ADDR_W(ADDR_W)) u_slice (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .bus         (port_bus[g]),
      .i_mem_rdata (mem_q[idx[g]]),
      .o_idx       (idx[g]),
      .o_wr_en     (wr_en[g]),
      .o_err       (port_err[g])
    );
  end

  host_state_e state_q, state_d;
  logic        any_busy;
  logic        host_wr;
  logic        host_rd;
  logic [7:0]  host_rdata_d, host_rdata_q;
  logic        err_d, err_q;
  logic [7:0]  cnt_d, cnt_q;
  logic [7:0]  n_coll;
  logic        first_wr;
  logic        shared_wr;

  always_comb begin
    any_busy     = |i_core_busy;
    state_d      = state_q;
    o_host_ready = 1'b0;
    host_wr      = 1'b0;
    host_rd      = 1'b0;
    unique case (state_q)
      HOST_IDLE: begin
        if (any_busy) begin
          state_d = HOST_LOCKED;
        end else begin
          o_host_ready = 1'b1;
          if (i_host_valid) begin
            if (i_host_we) begin
              host_wr = 1'b1;
            end else begin
              host_rd = 1'b1;
              state_d = HOST_RESP;
            end
          end
        end
      end
      HOST_LOCKED: if (!any_busy) state_d = HOST_IDLE;
      HOST_RESP:   state_d = any_busy ? HOST_LOCKED : HOST_IDLE;
      default:     state_d = HOST_IDLE;
    endcase
    host_rdata_d = host_rd ? mem_q[i_host_addr] : host_rdata_q;
    err_d        = err_q | (|port_err);
  end

  // Each colliding address is counted once, by its lowest-index writer.
  always_comb begin
    n_coll    = '0;
    first_wr  = 1'b0;
    shared_wr = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      first_wr  = wr_en[i];
      shared_wr = 1'b0;
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if (wr_en[j] && (idx[j] == idx[i])) begin
          if (j < i) first_wr  = 1'b0;
          if (j > i) shared_wr = 1'b1;
        end
      end
      if (first_wr && shared_wr) n_coll = n_coll + 8'd1;
    end
    cnt_d = sat_add8(cnt_q, n_coll);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= HOST_IDLE;
      host_rdata_q <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Later assignments win: host first, then ports from highest to lowest index.
  always_ff @(posedge i_clk) begin
    if (host_wr) mem_q[i_host_addr] <= i_host_wdata;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (wr_en[NUM_PORTS-1-i]) mem_q[idx[NUM_PORTS-1-i]] <= wdata[NUM_PORTS-1-i];
    end
  end

  assign o_host_rvalid  = (state_q == HOST_RESP);
  assign o_host_rdata   = host_rdata_q;
  assign o_err          = err_q;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: doc/dram_multiport_responder.md
Name: dram_multiport_responder

Overview:
- Memory-side responder for the core DRAM interface: the other end of each core's dram address/read/write/data bus.
- Serves NUM_PORTS cores in parallel from one shared byte-wide register-array memory with fixed latency; cores never stall.
- Provides a host side-port (valid/ready) to preload matrices and dump results; the host port is locked out while any core is busy.
- Sits at top level between the core array and the testbench/host loader.

Parameters:
- NUM_PORTS, 4, number of core ports served.
- ADDR_W, 8, implemented memory address bits; depth = 2**ADDR_W bytes.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_dram_addr  in  NUM_PORTS*16  per-port byte address; port k occupies bits [16k+15:16k].
- i_dram_read  in  NUM_PORTS*2  per-port read code.
- i_dram_write  in  NUM_PORTS*2  per-port write code.
- i_dram_wdata  in  NUM_PORTS*8  per-port write data.
- o_dram_rdata  out  NUM_PORTS*8  per-port registered read data.
- i_core_busy  in  NUM_PORTS  per-port core busy flags.
- i_host_valid  in  1  host request valid.
- i_host_we  in  1  1 = host write, 0 = host read.
- i_host_addr  in  ADDR_W  host address.
- i_host_wdata  in  8  host write data.
- o_host_ready  out  1  host request accepted when valid & ready.
- o_host_rvalid  out  1  one-cycle pulse qualifying o_host_rdata.
- o_host_rdata  out  8  host read data.
- o_err  out  1  sticky protocol error.
- o_conflict_cnt  out  8  saturating count of same-cycle write collisions.

Behaviour:
- Code encoding, read and write alike: 2'b01 = access; 2'b00 = idle; 2'b10 and 2'b11 are reserved, ignored, and set o_err.
- Address range: addr[15:ADDR_W] must be 0 on any access. A nonzero value sets o_err and suppresses that access: a write is dropped; a read leaves rdata unchanged.
- Read: address sampled at rising edge E. o_dram_rdata[k] is updated at E, so it is valid for the whole following cycle, and is held until the next valid read on port k. Latency is 1 cycle.
- Write: addr/wdata sampled at E; memory updated at E.
- Same-cycle read/write ordering: read-before-write. A read at E sees contents prior to any write at E; a read at E+1 sees the new value.
- Read and write both asserted on one port in the same cycle: the write is performed, the read is ignored, o_err is set.
- Write collision: two or more ports write the same address at the same edge. The lowest port index wins. o_conflict_cnt increments by 1 per colliding address per edge and saturates at 255.
- Host FSM, states:
  - LOCKED: |i_core_busy = 1; ready = 0.
  - IDLE: ready = 1.
  - RESP: rvalid = 1; ready = 0.
- Host FSM transitions:
  - IDLE -> LOCKED when any busy.
  - LOCKED -> IDLE when all busy are 0.
  - IDLE & valid & !we: latch read data, go to RESP.
  - IDLE & valid & we: write memory this edge, stay in IDLE.
  - RESP -> IDLE after 1 cycle (or -> LOCKED if busy).
- A core access in the same cycle as a host access is legal. The core write wins over the host write on the same address, and this is not counted as a collision.
- Reset values, applied immediately on reset assertion: all o_dram_rdata = 0; o_host_rdata = 0; o_host_rvalid = 0; o_err = 0; o_conflict_cnt = 0; FSM = IDLE (ready then follows busy).
- Memory contents are not reset.
- Reset asserted in RESP: the pending rvalid is dropped.

Decomposition:
- Shared package: read/write code constants (CODE_IDLE=2'b00, CODE_ACC=2'b01) and host FSM state encodings.
- One natural sub-module, dram_port_slice: per-port decode, range/error check, and rdata register; instantiated NUM_PORTS times.
- Memory array, write-priority logic and host FSM stay in the top.

Test Plan:
- Host writes 0xA5 to addr 0x10 with busy=0, then host read of 0x10 -> ready=1 at accept; rvalid pulses exactly 1 cycle later with rdata=0xA5.
- Port 2 read 0x0010 while port 0 writes 0x3C to 0x0010 on the same edge -> port 2 rdata=0xA5; a port 2 re-read the next cycle -> 0x3C.
- Ports 1 and 3 write 0x11/0x33 to 0x20 on the same edge -> memory 0x20=0x11; o_conflict_cnt=1. Repeat 300 times -> count=255.
- Port 0 read of 0x0100 (ADDR_W=8) -> o_err=1; rdata[0] unchanged. Separately, read code 2'b10 -> o_err=1.
- i_core_busy=4'b0100 with host valid held -> ready=0 throughout. Drop busy -> ready=1 next cycle; request accepted.
- Assert i_rstn=0 during RESP -> rvalid=0 immediately, all rdata=0, err=0, count=0; memory bytes retain their values.
